// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a synchronous single-port memory.
// Define MEM_ARB_STARVE_GUARD_EN to let starved fetches win contention.
module mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD_IF,
    RD_DM
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        st_ack;
  logic        st_ack_nx;
  logic [31:0] if_hold;
  logic [31:0] dm_hold;
  logic        mis;
  logic        dm_ok;
  logic        starve;
  logic        grant_if;
  logic        grant_dm;

  always_comb begin
    mis = 1'b0;
    case (dm_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = dm_addr[0];
      2'b10:   mis = |dm_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  assign starve = (wait_cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!if_req || grant_if) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      st_ack  <= 1'b0;
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      state  <= state_nx;
      st_ack <= st_ack_nx;
      if (state == RD_IF) begin
        if_hold <= mem_rdata;
      end
      if (state == RD_DM) begin
        dm_hold <= mem_rdata;
      end else if (st_ack) begin
        dm_hold <= '0;
      end
    end
  end

  // Combinational outputs are gated by reset so they read 0 while held.
  always_comb begin
    dm_ok     = 1'b0;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    if_stall  = 1'b0;
    dm_stall  = 1'b0;
    dm_err    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    state_nx  = IDLE;
    st_ack_nx = 1'b0;
    if (reset) begin
      dm_ok    = dm_req & ~mis;
      dm_err   = dm_req & mis;
      grant_if = if_req & (~dm_ok | starve);
      grant_dm = dm_ok & ~grant_if;
      if_stall = if_req & ~grant_if;
      dm_stall = dm_ok & ~grant_dm;
      if (grant_if) begin
        mem_en   = 1'b1;
        mem_size = 2'b10;
        mem_addr = if_addr;
        state_nx = RD_IF;
      end else if (grant_dm) begin
        mem_en   = 1'b1;
        mem_we   = dm_we;
        mem_size = dm_size;
        mem_addr = dm_addr;
        if (dm_we) begin
          mem_wdata = dm_wdata;
          st_ack_nx = 1'b1;
        end else begin
          state_nx = RD_DM;
        end
      end
    end
  end

  assign if_valid = (state == RD_IF);
  assign if_rdata = if_valid ? mem_rdata : if_hold;
  assign dm_valid = (state == RD_DM) | st_ack;
  assign dm_rdata = (state == RD_DM) ? mem_rdata :
                    st_ack ? 32'h0 : dm_hold;

endmodule
